// File: rtl/ddr2_write_burst8_if.sv
// Controller-side bus for the DDR2 write burst launcher: buffer load, start pulse,
// status, and the ODDR/tristate drive values.
interface ddr2_write_burst8_if #(
  parameter int DW = 16
);
  logic [DW-1:0] din;
  logic [1:0]    dmIn;
  logic [2:0]    wrPtr;
  logic          wrEn;
  logic          talk;
  logic          busy;
  logic          done;
  logic [DW-1:0] dq_rise;
  logic [DW-1:0] dq_fall;
  logic          dq_oe;
  logic [1:0]    dm_rise;
  logic [1:0]    dm_fall;
  logic          dqs_rise;
  logic          dqs_fall;
  logic          dqs_oe;

  modport master (
    output din, dmIn, wrPtr, wrEn, talk,
    input  busy, done, dq_rise, dq_fall, dq_oe, dm_rise, dm_fall,
           dqs_rise, dqs_fall, dqs_oe
  );

  modport slave (
    input  din, dmIn, wrPtr, wrEn, talk,
    output busy, done, dq_rise, dq_fall, dq_oe, dm_rise, dm_fall,
           dqs_rise, dqs_fall, dqs_oe
  );
endinterface

// File: rtl/ddr2_write_burst8.sv
// DDR2 write-direction DQ/DQS launcher: 8-word burst buffer, write-latency wait,
// DQS preamble, 4 double-rate data beats, DQS postamble. All outputs registered.
module ddr2_write_burst8 #(
  parameter int WL = 2,
  parameter int DW = 16
) (
  input logic               clk,
  input logic               reset_n,
  ddr2_write_burst8_if.slave bus
);
  // state  | meaning
  // S_IDLE | no burst, buffer writable, waiting for talk
  // S_WAIT | counting down write latency
  // S_PRE  | DQS preamble, DQ tristated
  // S_DATA | beat r_beat: two words per cycle
  // S_POST | DQS postamble, done=1
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_DATA, S_POST} state_t;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_lat, w_lat_nx;
  logic [1:0]    r_beat, w_beat_nx;
  logic [DW+1:0] r_buf [8];

  logic [DW+1:0] w_word_lo, w_word_hi;
  logic          w_busy, w_done, w_dq_oe, w_dqs_oe, w_dqs_rise;
  logic [DW-1:0] w_dq_rise, w_dq_fall;
  logic [1:0]    w_dm_rise, w_dm_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else if (bus.wrEn && (r_state == S_IDLE)) begin
      r_buf[bus.wrPtr] <= {bus.dmIn, bus.din};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lat   <= w_lat_nx;
      r_beat  <= w_beat_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_beat_nx  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (bus.talk) begin
          if (WL == 1) begin
            w_state_nx = S_PRE;
          end else begin
            w_state_nx = S_WAIT;
            w_lat_nx   = 4'(WL - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_lat <= 4'd1) begin
          w_state_nx = S_PRE;
          w_lat_nx   = '0;
        end else begin
          w_lat_nx = r_lat - 4'd1;
        end
      end
      S_PRE: begin
        w_state_nx = S_DATA;
        w_beat_nx  = '0;
      end
      S_DATA: begin
        if (r_beat == 2'd3) begin
          w_state_nx = S_POST;
          w_beat_nx  = '0;
        end else begin
          w_beat_nx = r_beat + 2'd1;
        end
      end
      S_POST:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  assign w_word_lo = r_buf[{w_beat_nx, 1'b0}];
  assign w_word_hi = r_buf[{w_beat_nx, 1'b1}];

  always_comb begin
    w_busy     = (w_state_nx != S_IDLE);
    w_done     = 1'b0;
    w_dq_oe    = 1'b0;
    w_dqs_oe   = 1'b0;
    w_dqs_rise = 1'b0;
    w_dq_rise  = '0;
    w_dq_fall  = '0;
    w_dm_rise  = '0;
    w_dm_fall  = '0;
    case (w_state_nx)
      S_PRE:  w_dqs_oe = 1'b1;
      S_DATA: begin
        w_dq_oe    = 1'b1;
        w_dqs_oe   = 1'b1;
        w_dqs_rise = 1'b1;
        w_dq_rise  = w_word_lo[DW-1:0];
        w_dq_fall  = w_word_hi[DW-1:0];
        w_dm_rise  = w_word_lo[DW+1:DW];
        w_dm_fall  = w_word_hi[DW+1:DW];
      end
      S_POST: begin
        w_dqs_oe = 1'b1;
        w_done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.dq_oe    <= 1'b0;
      bus.dqs_oe   <= 1'b0;
      bus.dqs_rise <= 1'b0;
      bus.dqs_fall <= 1'b0;
      bus.dq_rise  <= '0;
      bus.dq_fall  <= '0;
      bus.dm_rise  <= '0;
      bus.dm_fall  <= '0;
    end else begin
      bus.busy     <= w_busy;
      bus.done     <= w_done;
      bus.dq_oe    <= w_dq_oe;
      bus.dqs_oe   <= w_dqs_oe;
      bus.dqs_rise <= w_dqs_rise;
      bus.dqs_fall <= 1'b0;
      bus.dq_rise  <= w_dq_rise;
      bus.dq_fall  <= w_dq_fall;
      bus.dm_rise  <= w_dm_rise;
      bus.dm_fall  <= w_dm_fall;
    end
  end
endmodule
